timekeeper_hms: RTL

Parametrised hours/minutes/seconds timekeeper with a built-in second prescaler, bidirectional carry and borrow, per-field manual adjust without carry, a 12/24-hour display format and an hh:mm alarm pulse. It drives the BCD digit outputs of the clock display path. It is the next-generation replacement for the fixed 24-hour up/down modulo counter chain.

---
 rtl/clock_pkg.sv | 29 ++
 rtl/mod_updown_counter.sv | 33 +++
 rtl/timekeeper_hms.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the hh:mm:ss timekeeper.
// Field moduli, adjust-select encoding and BCD helper.
package clock_pkg;

    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;
    localparam int HR_MOD  = 24;

    typedef enum logic [1:0] {
        ADJ_NONE = 2'b00,
        ADJ_SEC  = 2'b01,
        ADJ_MIN  = 2'b10,
        ADJ_HR   = 2'b11
    } adj_sel_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Two-digit split of a small binary value (0..99).
    function automatic bcd_t bin_to_bcd(input logic [6:0] v);
        bcd_t r;
        r.tens  = 4'(v / 7'd10);
        r.units = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with direction-aware
// terminal flag for carry/borrow chaining.
module mod_updown_counter #(
    parameter int WIDTH = 6,
    parameter int MOD   = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    output logic [WIDTH-1:0] value,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

    // Last value before wrap in the current direction.
    assign terminal = up_down ? (value == TOP)
                              : (value == '0);

    // Step one position, wrapping at either end.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (en) begin
            if (up_down)
                value <= terminal ? '0 : value + 1'b1;
            else
                value <= terminal ? TOP : value - 1'b1;
        end
    end

endmodule

// File: rtl/timekeeper_hms.sv
// Hours/minutes/seconds timekeeper with prescaler,
// field adjust, 12/24h display and hh:mm alarm.
module timekeeper_hms
    import clock_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter bit FORMAT_12H = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       up_down,
    input  logic [1:0] adj_sel,
    input  logic       adj_pulse,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hours,
    input  logic [5:0] alarm_minutes,
    output logic [3:0] sec_units,
    output logic [2:0] sec_tens,
    output logic [3:0] min_units,
    output logic [2:0] min_tens,
    output logic [3:0] hr_units,
    output logic [1:0] hr_tens,
    output logic       pm,
    output logic       tick,
    output logic       alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          wrap;
    logic          sec_evt;
    adj_sel_e      sel_e;
    logic          adj_s;
    logic          adj_m;
    logic          adj_h;
    logic          adj_any;

    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       sec_term;
    logic       min_term;
    logic       hr_term;
    logic       en_sec;
    logic       en_min;
    logic       en_hr;

    logic [5:0] nxt_sec;
    logic [5:0] nxt_min;
    logic [4:0] nxt_hr;
    logic       alarm_hit;

    logic [4:0] hr_disp;
    bcd_t       sec_bcd;
    bcd_t       min_bcd;
    bcd_t       hr_bcd;
    logic       unused_bits;

    assign wrap  = run && (presc == PRE_MAX);
    assign sel_e = adj_sel_e'(adj_sel);

    // Prescaler: holds phase while run is low.
    always_ff @(posedge clk) begin
        if (rst)
            presc <= '0;
        else if (run)
            presc <= wrap ? '0 : presc + 1'b1;
    end

    // Decode the adjust request into one field strobe.
    always_comb begin
        adj_s = 1'b0;
        adj_m = 1'b0;
        adj_h = 1'b0;
        if (adj_pulse) begin
            unique case (1'b1)
                (sel_e == ADJ_SEC): adj_s = 1'b1;
                (sel_e == ADJ_MIN): adj_m = 1'b1;
                (sel_e == ADJ_HR):  adj_h = 1'b1;
                default: ;
            endcase
        end
    end

    assign adj_any = adj_s | adj_m | adj_h;

    // An adjust swallows a coincident second event.
    assign sec_evt = wrap & ~adj_any;

    assign en_sec = adj_s | sec_evt;
    assign en_min = adj_m | (sec_evt & sec_term);
    assign en_hr  = adj_h
                  | (sec_evt & sec_term & min_term);

    mod_updown_counter #(
        .WIDTH (6),
        .MOD   (SEC_MOD)
    ) u_sec (
        .clk      (clk),
        .rst      (rst),
        .en       (en_sec),
        .up_down  (up_down),
        .value    (sec),
        .terminal (sec_term)
    );

    mod_updown_counter #(
        .WIDTH (6),
        .MOD   (MIN_MOD)
    ) u_min (
        .clk      (clk),
        .rst      (rst),
        .en       (en_min),
        .up_down  (up_down),
        .value    (min),
        .terminal (min_term)
    );

    mod_updown_counter #(
        .WIDTH (5),
        .MOD   (HR_MOD)
    ) u_hr (
        .clk      (clk),
        .rst      (rst),
        .en       (en_hr),
        .up_down  (up_down),
        .value    (hr),
        .terminal (hr_term)
    );

    // Time that a counted second would produce.
    always_comb begin
        nxt_sec = sec;
        nxt_min = min;
        nxt_hr  = hr;
        if (up_down) begin
            nxt_sec = sec_term ? 6'd0 : sec + 6'd1;
            if (sec_term) begin
                nxt_min = min_term ? 6'd0 : min + 6'd1;
                if (min_term)
                    nxt_hr = hr_term ? 5'd0 : hr + 5'd1;
            end
        end else begin
            nxt_sec = sec_term ? 6'd59 : sec - 6'd1;
            if (sec_term) begin
                nxt_min = min_term ? 6'd59 : min - 6'd1;
                if (min_term)
                    nxt_hr = hr_term ? 5'd23 : hr - 5'd1;
            end
        end
    end

    assign alarm_hit = alarm_en
                    && (nxt_sec == 6'd0)
                    && (nxt_min == alarm_minutes)
                    && (nxt_hr == alarm_hours);

    // Event strobes land together with the new time.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick  <= 1'b0;
            alarm <= 1'b0;
        end else begin
            tick  <= sec_evt;
            alarm <= sec_evt & alarm_hit;
        end
    end

    // Hour value as shown in the selected format.
    always_comb begin
        hr_disp = hr;
        pm      = 1'b0;
        if (FORMAT_12H) begin
            pm      = (hr >= 5'd12);
            hr_disp = pm ? hr - 5'd12 : hr;
            if (hr_disp == 5'd0)
                hr_disp = 5'd12;
        end
    end

    assign sec_bcd = bin_to_bcd(7'(sec));
    assign min_bcd = bin_to_bcd(7'(min));
    assign hr_bcd  = bin_to_bcd(7'(hr_disp));

    assign sec_units = sec_bcd.units;
    assign sec_tens  = sec_bcd.tens[2:0];
    assign min_units = min_bcd.units;
    assign min_tens  = min_bcd.tens[2:0];
    assign hr_units  = hr_bcd.units;
    assign hr_tens   = hr_bcd.tens[1:0];

    assign unused_bits = ^{sec_bcd.tens[3],
                           min_bcd.tens[3],
                           hr_bcd.tens[3:2]};

endmodule
